// File: rtl/ber_sync_scanner.sv
// ber_sync_scanner: scans every (latency, phase) candidate of the BER checker,
// locks onto the one with the fewest window errors, and keeps tracking it.
//
// state    | meaning
// IDLE     | disabled, all registers at reset values
// S_SETTLE | acquisition: discard N_SETTLE strobes after a position change
// S_MEAS   | acquisition: count errors over N_WINDOW strobes
// S_EVAL   | acquisition: compare with best, advance to next candidate
// APPLY    | lock onto best candidate, or restart the scan if none is good
// T_SETTLE | tracking: discard N_SETTLE strobes after moving to best
// T_MEAS   | tracking: count errors over N_WINDOW strobes
// T_EVAL   | tracking: update consecutive-bad count, rescan on loss
module ber_sync_scanner #(
  parameter int NB_SEL   = 2,
  parameter int N_PHASES = 4,
  parameter int NB_LAT   = 9,
  parameter int N_LAT    = 511,
  parameter int NB_COUNT = 9,
  parameter int N_WINDOW = 511,
  parameter int N_SETTLE = 8,
  parameter int LOCK_THR = 100,
  parameter int N_LOSS   = 3
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sym_valid,
  input  logic                i_err,
  output logic [NB_SEL-1:0]   o_phase_sel,
  output logic [NB_LAT-1:0]   o_lat_pos,
  output logic                o_lock,
  output logic                o_scanning,
  output logic [NB_COUNT-1:0] o_best_err,
  output logic [NB_COUNT-1:0] o_win_err
);

  typedef enum logic [2:0] {
    IDLE, S_SETTLE, S_MEAS, S_EVAL, APPLY, T_SETTLE, T_MEAS, T_EVAL
  } state_t;

  localparam int TMR_MAX = (N_WINDOW > N_SETTLE) ? N_WINDOW : N_SETTLE;
  localparam int NB_TMR  = $clog2(TMR_MAX + 1);
  localparam int NB_BAD  = $clog2(N_LOSS + 1);

  localparam logic [NB_TMR-1:0]   TMR_SETTLE = NB_TMR'(N_SETTLE - 1);
  localparam logic [NB_TMR-1:0]   TMR_WIN    = NB_TMR'(N_WINDOW - 1);
  localparam logic [NB_SEL-1:0]   PH_LAST    = NB_SEL'(N_PHASES - 1);
  localparam logic [NB_LAT-1:0]   LAT_LAST   = NB_LAT'(N_LAT - 1);
  localparam logic [NB_COUNT-1:0] THR        = NB_COUNT'(LOCK_THR);
  localparam logic [NB_COUNT-1:0] CNT_MAX    = {NB_COUNT{1'b1}};
  localparam logic [NB_BAD-1:0]   BAD_LOSS   = NB_BAD'(N_LOSS);

  state_t                state_q, state_d;
  logic [NB_SEL-1:0]     phase_q, phase_d;
  logic [NB_LAT-1:0]     lat_q, lat_d;
  logic [NB_COUNT-1:0]   best_q, best_d;
  logic [NB_SEL-1:0]     best_phase_q, best_phase_d;
  logic [NB_LAT-1:0]     best_lat_q, best_lat_d;
  logic [NB_COUNT-1:0]   cnt_q, cnt_d;
  logic [NB_TMR-1:0]     tmr_q, tmr_d;
  logic [NB_BAD-1:0]     bad_q, bad_d;
  logic                  lock_q, lock_d;
  logic                  scanning_q, scanning_d;
  logic [NB_COUNT-1:0]   win_err_q, win_err_d;
  logic [NB_BAD-1:0]     bad_inc;

  // Next-state and register update logic; i_enable low forces the reset image.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    lat_d        = lat_q;
    best_d       = best_q;
    best_phase_d = best_phase_q;
    best_lat_d   = best_lat_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    bad_d        = bad_q;
    lock_d       = lock_q;
    scanning_d   = scanning_q;
    win_err_d    = win_err_q;
    bad_inc      = (cnt_q > THR) ? bad_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        state_d      = S_SETTLE;
        phase_d      = '0;
        lat_d        = '0;
        best_d       = CNT_MAX;
        best_phase_d = '0;
        best_lat_d   = '0;
        scanning_d   = 1'b1;
        tmr_d        = TMR_SETTLE;
      end
      S_SETTLE, T_SETTLE: begin
        if (i_sym_valid) begin
          if (tmr_q == '0) begin
            state_d = (state_q == S_SETTLE) ? S_MEAS : T_MEAS;
            cnt_d   = '0;
            tmr_d   = TMR_WIN;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      S_MEAS, T_MEAS: begin
        if (i_sym_valid) begin
          if (i_err && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
          if (tmr_q == '0) state_d = (state_q == S_MEAS) ? S_EVAL : T_EVAL;
          else             tmr_d   = tmr_q - 1'b1;
        end
      end
      S_EVAL: begin
        win_err_d = cnt_q;
        tmr_d     = TMR_SETTLE;
        if (cnt_q < best_q) begin
          best_d       = cnt_q;
          best_phase_d = phase_q;
          best_lat_d   = lat_q;
        end
        if (phase_q == PH_LAST) begin
          if (lat_q == LAT_LAST) begin
            state_d = APPLY;
          end else begin
            phase_d = '0;
            lat_d   = lat_q + 1'b1;
            state_d = S_SETTLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      APPLY: begin
        tmr_d = TMR_SETTLE;
        if (best_q <= THR) begin
          phase_d    = best_phase_q;
          lat_d      = best_lat_q;
          lock_d     = 1'b1;
          scanning_d = 1'b0;
          bad_d      = '0;
          state_d    = T_SETTLE;
        end else begin
          phase_d      = '0;
          lat_d        = '0;
          best_d       = CNT_MAX;
          best_phase_d = '0;
          best_lat_d   = '0;
          state_d      = S_SETTLE;
        end
      end
      T_EVAL: begin
        win_err_d = cnt_q;
        if (bad_inc == BAD_LOSS) begin
          lock_d       = 1'b0;
          scanning_d   = 1'b1;
          phase_d      = '0;
          lat_d        = '0;
          best_d       = CNT_MAX;
          best_phase_d = '0;
          best_lat_d   = '0;
          bad_d        = '0;
          tmr_d        = TMR_SETTLE;
          state_d      = S_SETTLE;
        end else begin
          bad_d   = bad_inc;
          cnt_d   = '0;
          tmr_d   = TMR_WIN;
          state_d = T_MEAS;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_enable) begin
      state_d      = IDLE;
      phase_d      = '0;
      lat_d        = '0;
      best_d       = CNT_MAX;
      best_phase_d = '0;
      best_lat_d   = '0;
      cnt_d        = '0;
      tmr_d        = '0;
      bad_d        = '0;
      lock_d       = 1'b0;
      scanning_d   = 1'b0;
      win_err_d    = '0;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      lat_q        <= '0;
      best_q       <= CNT_MAX;
      best_phase_q <= '0;
      best_lat_q   <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      bad_q        <= '0;
      lock_q       <= 1'b0;
      scanning_q   <= 1'b0;
      win_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lat_q        <= lat_d;
      best_q       <= best_d;
      best_phase_q <= best_phase_d;
      best_lat_q   <= best_lat_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      bad_q        <= bad_d;
      lock_q       <= lock_d;
      scanning_q   <= scanning_d;
      win_err_q    <= win_err_d;
    end
  end

  assign o_phase_sel = phase_q;
  assign o_lat_pos   = lat_q;
  assign o_lock      = lock_q;
  assign o_scanning  = scanning_q;
  assign o_best_err  = best_q;
  assign o_win_err   = win_err_q;

endmodule

// File: tb/tb_ber_sync_scanner.sv
// Testbench for ber_sync_scanner with a small scan (3 latencies x 4 phases).
module tb_ber_sync_scanner;

  localparam int NL    = 3;
  localparam int NP    = 4;
  localparam int NW    = 8;
  localparam int NS    = 2;
  localparam int THR   = 1;
  localparam int NLOSS = 2;
  localparam int NC    = NL * NP;
  localparam logic [30:0] RST_IMG = {2'd0, 9'd0, 1'b0, 1'b0, 9'h1FF, 9'd0};

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_sym_valid = 1'b0;
  logic       i_err = 1'b0;
  logic [1:0] o_phase_sel;
  logic [8:0] o_lat_pos;
  logic       o_lock;
  logic       o_scanning;
  logic [8:0] o_best_err;
  logic [8:0] o_win_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] plan [NC];

  always #5 clock = ~clock;

  ber_sync_scanner #(
    .NB_SEL(2), .N_PHASES(NP), .NB_LAT(9), .N_LAT(NL), .NB_COUNT(9),
    .N_WINDOW(NW), .N_SETTLE(NS), .LOCK_THR(THR), .N_LOSS(NLOSS)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_sym_valid (i_sym_valid),
    .i_err       (i_err),
    .o_phase_sel (o_phase_sel),
    .o_lat_pos   (o_lat_pos),
    .o_lock      (o_lock),
    .o_scanning  (o_scanning),
    .o_best_err  (o_best_err),
    .o_win_err   (o_win_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // one strobe followed by three idle cycles (strobe every 4 clocks)
  task automatic strobe(input logic e);
    i_sym_valid = 1'b1;
    i_err       = e;
    tick();
    i_sym_valid = 1'b0;
    i_err       = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_settle();
    for (int k = 0; k < NS; k++) strobe(1'($urandom_range(0, 1)));
  endtask

  task automatic run_window(input logic [7:0] m);
    for (int j = 0; j < NW; j++) strobe(m[j]);
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    repeat (2) tick();
    i_reset = 1'b0;
  endtask

  task automatic start();
    i_enable = 1'b1;
    repeat (2) tick();
  endtask

  // Full acquisition pass over plan[]; checks every window count and the APPLY result.
  task automatic acquire(input string tag, output bit locked);
    int best_cnt;
    int best_idx;
    int c_cnt;
    best_cnt = 1 << 30;
    best_idx = 0;
    for (int c = 0; c < NC; c++) begin
      c_cnt = $countones(plan[c]);
      if (c_cnt < best_cnt) begin
        best_cnt = c_cnt;
        best_idx = c;
      end
    end
    for (int c = 0; c < NC; c++) begin
      run_settle();
      run_window(plan[c]);
      n_tests++;
      if (o_win_err !== 9'($countones(plan[c]))) begin
        n_fail++;
        $display("FAIL %0s win_err cand %0d: got %0d expected %0d", tag, c, o_win_err,
                 $countones(plan[c]));
      end
    end
    locked = (best_cnt <= THR);
    n_tests++;
    if (locked) begin
      if ({o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err} !==
          {1'b1, 1'b0, 2'(best_idx % NP), 9'(best_idx / NP), 9'(best_cnt)}) begin
        n_fail++;
        $display("FAIL %0s apply_lock: got lock=%0b scan=%0b ph=%0d lat=%0d best=%0d expected 1 0 %0d %0d %0d",
                 tag, o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err,
                 best_idx % NP, best_idx / NP, best_cnt);
      end
    end else begin
      if ({o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err} !==
          {1'b0, 1'b1, 2'd0, 9'd0, 9'h1FF}) begin
        n_fail++;
        $display("FAIL %0s apply_rescan: got lock=%0b scan=%0b ph=%0d lat=%0d best=%0d expected 0 1 0 0 511",
                 tag, o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err);
      end
    end
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_enable = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err} !== RST_IMG) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h",
               {o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err}, RST_IMG);
    end
    i_reset = 1'b0;
    for (int k = 0; k < 6; k++) strobe(1'($urandom_range(0, 1)));
    n_tests++;
    if ({o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err} !== RST_IMG) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h",
               {o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err}, RST_IMG);
    end
  endtask

  task automatic test_single_clean();
    bit lk;
    do_reset();
    for (int c = 0; c < NC; c++) plan[c] = 8'hFF;
    plan[1 * NP + 2] = 8'h00;
    start();
    n_tests++;
    if (o_scanning !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_start: got scanning=%0b expected 1", o_scanning);
    end
    acquire("single_clean", lk);
  endtask

  task automatic test_tie_break();
    bit lk;
    do_reset();
    for (int c = 0; c < NC; c++) plan[c] = 8'h0F;
    plan[0 * NP + 3] = 8'h00;
    plan[2 * NP + 1] = 8'h00;
    start();
    acquire("tie_break", lk);
  endtask

  task automatic test_no_candidate();
    bit lk;
    do_reset();
    for (int c = 0; c < NC; c++) plan[c] = 8'hFF;
    start();
    acquire("no_cand", lk);
    // second pass continues straight after the failed APPLY
    for (int c = 0; c < NC; c++) plan[c] = 8'hFF;
    plan[NC - 1] = 8'h01;
    acquire("no_cand_rescan", lk);
  endtask

  task automatic test_loss_of_lock();
    bit lk;
    logic [7:0] m5;
    m5 = 8'b1011_0101;
    do_reset();
    for (int c = 0; c < NC; c++) plan[c] = 8'hFF;
    plan[1 * NP + 1] = 8'h00;
    start();
    acquire("loss_acq", lk);
    run_settle();
    run_window(m5);
    n_tests++;
    if ({o_win_err, o_lock, o_phase_sel, o_lat_pos} !== {9'd5, 1'b1, 2'd1, 9'd1}) begin
      n_fail++;
      $display("FAIL loss_one_bad: got win=%0d lock=%0b ph=%0d lat=%0d expected 5 1 1 1",
               o_win_err, o_lock, o_phase_sel, o_lat_pos);
    end
    run_window(8'h00);
    n_tests++;
    if ({o_win_err, o_lock} !== {9'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL loss_clean: got win=%0d lock=%0b expected 0 1", o_win_err, o_lock);
    end
    run_window(m5);
    n_tests++;
    if ({o_win_err, o_lock, o_best_err} !== {9'd5, 1'b1, 9'd0}) begin
      n_fail++;
      $display("FAIL loss_bad1: got win=%0d lock=%0b best=%0d expected 5 1 0",
               o_win_err, o_lock, o_best_err);
    end
    run_window(m5);
    n_tests++;
    if ({o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err} !==
        {9'd5, 1'b0, 1'b1, 2'd0, 9'd0, 9'h1FF}) begin
      n_fail++;
      $display("FAIL loss_bad2: got win=%0d lock=%0b scan=%0b ph=%0d lat=%0d best=%0d expected 5 0 1 0 0 511",
               o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos, o_best_err);
    end
    for (int c = 0; c < NC; c++) plan[c] = 8'($urandom);
    plan[2] = 8'h40;
    acquire("loss_rescan", lk);
  endtask

  task automatic test_abort();
    bit lk;
    do_reset();
    for (int c = 0; c < NC; c++) plan[c] = 8'hFF;
    start();
    run_settle();
    for (int j = 0; j < 3; j++) strobe(1'b1);
    i_enable = 1'b0;
    tick();
    n_tests++;
    if ({o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err} !== RST_IMG) begin
      n_fail++;
      $display("FAIL abort_enable: got %h expected %h",
               {o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err}, RST_IMG);
    end
    plan[7] = 8'h00;
    start();
    acquire("abort_restart", lk);
    run_settle();
    run_window(8'h00);
    i_reset = 1'b1;
    tick();
    n_tests++;
    if ({o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err} !== RST_IMG) begin
      n_fail++;
      $display("FAIL abort_reset: got %h expected %h",
               {o_phase_sel, o_lat_pos, o_lock, o_scanning, o_best_err, o_win_err}, RST_IMG);
    end
    i_reset = 1'b0;
    tick();
    n_tests++;
    if ({o_scanning, o_lock, o_phase_sel, o_lat_pos} !== {1'b1, 1'b0, 2'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL abort_rescan: got scan=%0b lock=%0b ph=%0d lat=%0d expected 1 0 0 0",
               o_scanning, o_lock, o_phase_sel, o_lat_pos);
    end
    for (int c = 0; c < NC; c++) plan[c] = 8'($urandom) | 8'h03;
    plan[10] = 8'h00;
    acquire("abort_reacq", lk);
  endtask

  // Random candidate error patterns followed by random tracking windows.
  task automatic test_random();
    bit lk;
    int bad;
    int exp_ph;
    int exp_lat;
    int r;
    logic [7:0] m;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < NC; c++) begin
        r = $urandom_range(0, 3);
        if (r == 0)      plan[c] = 8'h00;
        else if (r == 1) plan[c] = 8'(1 << $urandom_range(0, 7));
        else             plan[c] = 8'($urandom) | 8'h11;
      end
      start();
      acquire("random", lk);
      if (lk) begin
        exp_ph  = o_phase_sel;
        exp_lat = o_lat_pos;
        run_settle();
        bad = 0;
        for (int w = 0; w < 6; w++) begin
          r = $urandom_range(0, 2);
          m = (r == 0) ? 8'h00 : ((r == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'hF3);
          run_window(m);
          if ($countones(m) > THR) bad++;
          else bad = 0;
          n_tests++;
          if (bad == NLOSS) begin
            if ({o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos} !==
                {9'($countones(m)), 1'b0, 1'b1, 2'd0, 9'd0}) begin
              n_fail++;
              $display("FAIL random_track_loss w=%0d: got win=%0d lock=%0b scan=%0b ph=%0d lat=%0d expected %0d 0 1 0 0",
                       w, o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos, $countones(m));
            end
            break;
          end else begin
            if ({o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos} !==
                {9'($countones(m)), 1'b1, 1'b0, 2'(exp_ph), 9'(exp_lat)}) begin
              n_fail++;
              $display("FAIL random_track w=%0d: got win=%0d lock=%0b scan=%0b ph=%0d lat=%0d expected %0d 1 0 %0d %0d",
                       w, o_win_err, o_lock, o_scanning, o_phase_sel, o_lat_pos,
                       $countones(m), exp_ph, exp_lat);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_clean();
    test_tie_break();
    test_no_candidate();
    test_loss_of_lock();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ber_sync_scanner.md
# ber_sync_scanner

Acquisition and tracking controller for the receiver BER checker. It sequences the sampling-phase selector and the PRBS latency tap across every (latency, phase) candidate. For each candidate it counts symbol errors over a fixed window and locks onto the candidate with the fewest errors. While locked it keeps measuring and restarts acquisition on sustained loss of lock. It sits between the receive filter/decision path and the LED/status logic, and drives the phase-select and latency-position inputs of the error-checking datapath.

## Interface
- NB_SEL, 2, phase-select width
- N_PHASES, 4, number of sampling phases (≤ 2^NB_SEL)
- NB_LAT, 9, latency-position width
- N_LAT, 511, number of latency taps scanned (≤ 2^NB_LAT)
- NB_COUNT, 9, error-counter width
- N_WINDOW, 511, symbol strobes per measurement window
- N_SETTLE, 8, symbol strobes discarded after every position change
- LOCK_THR, 100, maximum window error count accepted as "good"
- N_LOSS, 3, consecutive bad tracking windows that force a rescan

Ports:
- clock  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_enable  in  1  receiver enable; low returns the block to IDLE
- i_sym_valid  in  1  one-cycle symbol strobe (same cadence as the checker's PRBS enable)
- i_err  in  1  decoded-bit XOR reference bit for the current position; qualified by i_sym_valid
- o_phase_sel  out  NB_SEL  phase selector to the checker
- o_lat_pos  out  NB_LAT  PRBS latency tap to the checker
- o_lock  out  1  locked to the best candidate
- o_scanning  out  1  acquisition in progress
- o_best_err  out  NB_COUNT  error count of the best candidate found
- o_win_err  out  NB_COUNT  error count of the last completed window

## Operation
- States: IDLE, S_SETTLE, S_MEAS, S_EVAL, APPLY, T_SETTLE, T_MEAS, T_EVAL.
- **IDLE:** all outputs at reset values. When i_enable=1, go to S_SETTLE with phase=0, lat=0, best=all-ones, o_scanning=1.
- **SETTLE states:** count N_SETTLE strobes and ignore i_err. Then go to the matching MEAS state with the error counter cleared.
- **MEAS states:** count N_WINDOW strobes. On each strobe, add i_err to the error counter, saturating at 2^NB_COUNT−1. The strobe that completes the window is counted; the next cycle enters EVAL.
- **S_EVAL** (1 cycle): o_win_err←count.
  - If count < best (strict), update best, best_phase and best_lat. Ties keep the earlier candidate.
  - Advance the position: phase+1 (inner loop). After phase N_PHASES−1, phase returns to 0 and lat+1. After the last (lat, phase) candidate, go to APPLY; otherwise go to S_SETTLE.
- **APPLY** (1 cycle):
  - If best ≤ LOCK_THR: drive best_phase/best_lat, set o_lock=1, o_scanning=0, bad=0, go to T_SETTLE.
  - Otherwise: restart the scan at (0,0) with best=all-ones and o_scanning held at 1.
- **T_EVAL** (1 cycle): o_win_err←count.
  - If count > LOCK_THR, bad+1; else bad=0.
  - If bad reaches N_LOSS: o_lock=0, o_scanning=1, position=(0,0), best=all-ones, go to S_SETTLE.
  - Otherwise go to T_MEAS (no re-settle; the position is unchanged).
- o_best_err is frozen during tracking and reflects the value from acquisition.
- Strobes arriving in EVAL or APPLY cycles are dropped and do not count toward settle or window.
- i_enable=0 in any state: the next state is IDLE and all registers are cleared, identical to reset.
- The scan order is deterministic, so the first-found minimum wins.

## Timing
- Reset values:
  - o_phase_sel=0, o_lat_pos=0
  - o_lock=0, o_scanning=0
  - o_best_err=all-ones, o_win_err=0
- All outputs are registered.
- Position changes happen on the edge leaving S_EVAL or APPLY and are visible in the first SETTLE cycle.
- o_lock rises on the edge leaving APPLY and falls on the edge leaving the T_EVAL that detects the loss.
- One acquisition pass takes N_LAT·N_PHASES·(N_SETTLE+N_WINDOW) strobes plus one EVAL cycle per candidate and one APPLY cycle.
- Upstream guarantees i_sym_valid strobes are separated by ≥1 idle cycle, so at most one strobe is lost per EVAL/APPLY.
- Reset mid-operation takes effect on the next edge. The same applies to i_enable deassertion.

## Test plan
All scenarios use N_LAT=3, N_WINDOW=8, N_SETTLE=2, LOCK_THR=1, N_LOSS=2, with a strobe every 4 clocks.

1. **Reset values:** assert reset, then hold i_enable=0 → outputs at reset values; o_best_err=511, state stays IDLE.
2. **Single clean candidate:** i_err=1 on every strobe except at (lat=1, phase=2) → after 12 windows, o_lock=1, o_phase_sel=2, o_lat_pos=1, o_best_err=0, o_scanning=0.
3. **Tie-break:** zero errors at both (0,3) and (2,1) → lock at lat 0, phase 3.
4. **No acceptable candidate:** i_err=1 on every strobe → every o_win_err=8. After APPLY, o_lock stays 0, position returns to (0,0) and o_scanning stays 1.
5. **Loss of lock:** while locked, one window with 5 errors followed by a clean window → stays locked. Two consecutive windows with 5 errors → o_lock falls on the second T_EVAL and the rescan starts at (0,0).
6. **Abort mid-operation:** drop i_enable mid-S_MEAS → IDLE on the next cycle with reset outputs. Assert i_reset during tracking → same result. Raising i_enable again restarts the scan from (0,0).
